// File: rtl/cmd_bits.sv
// Command byte bit positions shared with dev_fsm-style devices.
// Pure constants, no logic.
// Bit set in the command byte enables the corresponding phase or operation.
package cmd_bits;
    localparam int b_op_1   = 0;
    localparam int b_op_2   = 1;
    localparam int b_addop  = 2;
    localparam int b_addres = 3;
    localparam int b_tx     = 4;
endpackage

// File: rtl/dev_host_pkg.sv
// Shared types and defaults for the dev_host controller.
// Pure declarations, no logic.
// Not applicable.
package dev_host_pkg;
    localparam int TO_CYC_DEF = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BUSY = 3'd1,
        CMD       = 3'd2,
        OP1       = 3'd3,
        OP2       = 3'd4,
        RD_WAIT   = 3'd5
    } host_state_t;
endpackage

// File: rtl/dev_host_ctrl_if.sv
// Request/response port plus device-side pins of the dev_host controller.
// Wires only, no latency.
// slave = controller view; master = requester/device view (drives the inputs).
interface dev_host_ctrl_if #(
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_cmd;
    logic [DW-1:0] req_op1;
    logic [DW-1:0] req_op2;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          dev_cs;
    logic [DW-1:0] dev_din;
    logic          dev_busy;
    logic [DW-1:0] dev_dout;
    logic          dev_drdy;

    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2, dev_busy, dev_dout, dev_drdy,
        output req_ready, rsp_valid, rsp_data, rsp_err, dev_cs, dev_din
    );

    modport master (
        output req_valid, req_cmd, req_op1, req_op2, dev_busy, dev_dout, dev_drdy,
        input  req_ready, rsp_valid, rsp_data, rsp_err, dev_cs, dev_din
    );
endinterface

// File: rtl/dev_host_timer.sv
// Saturating cycle counter used as the read-data timeout.
// expire is combinational from the count; count updates on posedge.
// No handshake: clr dominates en; count sticks at TO_CYC-1 instead of wrapping.
module dev_host_timer
    import dev_host_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int TW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(TO_CYC - 1);

    logic [TW-1:0] cnt;

    // count cycles while enabled, hold at LAST so a late drdy never sees a wrapped value
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expire = (cnt == LAST);
endmodule

// File: rtl/dev_host_ctrl.sv
// Bus master sequencing cs/din for one cmd+op1+op2 request, returning read data or timeout.
// Idle device: cs 2 cycles after accept; response strobe 1 cycle after the completing state.
// req_ready only in IDLE; device busy stalls in WAIT_BUSY indefinitely; no response backpressure.
module dev_host_ctrl
    import cmd_bits::*;
    import dev_host_pkg::*;
#(
    parameter int DW     = 8,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    dev_host_ctrl_if.slave  bus
);
    host_state_t   state;
    host_state_t   state_nxt;
    logic [DW-1:0] cmd_q;
    logic [DW-1:0] op1_q;
    logic [DW-1:0] op2_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic          ready;
    logic          cs;
    logic [DW-1:0] din;
    logic          done_wr;
    logic          tmr_expire;

    dev_host_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != RD_WAIT),
        .en     (state == RD_WAIT),
        .expire (tmr_expire)
    );

    // next-state selection and Moore outputs decoded from the registered state
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        cs        = 1'b0;
        din       = '0;
        done_wr   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.dev_busy) state_nxt = CMD;
            end
            CMD: begin
                cs  = 1'b1;
                din = cmd_q;
                if (cmd_q[b_op_1])      state_nxt = OP1;
                else if (cmd_q[b_op_2]) state_nxt = OP2;
                else if (cmd_q[b_tx])   state_nxt = RD_WAIT;
                else begin
                    state_nxt = IDLE;
                    done_wr   = 1'b1;
                end
            end
            OP1: begin
                din = op1_q;
                if (cmd_q[b_op_2])    state_nxt = OP2;
                else if (cmd_q[b_tx]) state_nxt = RD_WAIT;
                else begin
                    state_nxt = IDLE;
                    done_wr   = 1'b1;
                end
            end
            OP2: begin
                din = op2_q;
                if (cmd_q[b_tx]) state_nxt = RD_WAIT;
                else begin
                    state_nxt = IDLE;
                    done_wr   = 1'b1;
                end
            end
            RD_WAIT: begin
                if (bus.dev_drdy || tmr_expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register, request latches and registered response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state       <= state_nxt;
            rsp_valid_q <= 1'b0;
            if (state == IDLE && bus.req_valid) begin
                cmd_q <= bus.req_cmd;
                op1_q <= bus.req_op1;
                op2_q <= bus.req_op2;
            end
            if (done_wr) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
            end
            // drdy takes priority over a timeout landing in the same cycle
            if (state == RD_WAIT) begin
                if (bus.dev_drdy) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= bus.dev_dout;
                end else if (tmr_expire) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= '0;
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.dev_cs    = cs;
    assign bus.dev_din   = din;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule
